serial_add_sub_ctrl: RTL and testbench



---
 rtl/serial_add_sub_pkg.sv | 17 +
 rtl/full_adder_1.sv | 13 +
 rtl/serial_add_sub_ctrl.sv | 125 ++++++++++++
 tb/tb_serial_add_sub_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_sub_pkg.sv
// rtl/serial_add_sub_pkg.sv - shared types and sizing helper for the bit-serial adder/subtractor
package serial_add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must hold the value N after the last RUN cycle.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/full_adder_1.sv
// rtl/full_adder_1.sv - single-bit full adder cell
module full_adder_1 (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic s,
    output logic carry_out
);

    assign s         = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule

// File: rtl/serial_add_sub_ctrl.sv
// rtl/serial_add_sub_ctrl.sv - LSB-first bit-serial N-bit add/sub with start/ready, valid/ack handshake
// Optional signed overflow output enabled by SERIAL_ADD_SUB_OVERFLOW_EN.
module serial_add_sub_ctrl
    import serial_add_sub_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic         i_sub,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_ready,
    output logic         o_valid,
    input  logic         i_ack,
    output logic [N-1:0] o_result,
    output logic         o_carry
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
    ,
    output logic         o_overflow
`endif
);

    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  a_sr_q, a_sr_d;
    logic [N-1:0]  b_sr_q, b_sr_d;
    logic [N-1:0]  res_sr_q, res_sr_d;
    logic          carry_q, carry_d;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
    logic          ovf_q, ovf_d;
`endif

    logic fa_s;
    logic fa_co;

    full_adder_1 u_fa (
        .a         (a_sr_q[0]),
        .b         (b_sr_q[0]),
        .carry_in  (carry_q),
        .s         (fa_s),
        .carry_out (fa_co)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        carry_d  = carry_q;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    // Subtraction as A + ~B + 1: the +1 rides in on the initial carry.
                    a_sr_d  = i_a;
                    b_sr_d  = i_sub ? ~i_b : i_b;
                    carry_d = i_sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d          = fa_co;
                res_sr_d         = res_sr_q >> 1;
                res_sr_d[N-1]    = fa_s;
                a_sr_d           = a_sr_q >> 1;
                b_sr_d           = b_sr_q >> 1;
                cnt_d            = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
                    ovf_d = carry_q ^ fa_co;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            carry_q  <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            carry_q  <= carry_d;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign o_ready  = (state_q == IDLE);
    assign o_valid  = (state_q == DONE);
    assign o_result = res_sr_q;
    assign o_carry  = carry_q;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
    assign o_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
// tb/tb_serial_add_sub_ctrl.sv - directed table-driven bench for serial_add_sub_ctrl (N=8)
module tb_serial_add_sub_ctrl;

    localparam int N = 8;

    logic         clk;
    logic         i_reset;
    logic         i_start;
    logic         i_sub;
    logic [N-1:0] i_a;
    logic [N-1:0] i_b;
    logic         o_ready;
    logic         o_valid;
    logic         i_ack;
    logic [N-1:0] o_result;
    logic         o_carry;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
    logic         o_overflow;
`endif

    serial_add_sub_ctrl #(.N(N)) dut (
        .i_clk    (clk),
        .i_reset  (i_reset),
        .i_start  (i_start),
        .i_sub    (i_sub),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_ready  (o_ready),
        .o_valid  (o_valid),
        .i_ack    (i_ack),
        .o_result (o_result),
        .o_carry  (o_carry)
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
        ,
        .o_overflow (o_overflow)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         sub;
        logic [N-1:0] exp_res;
        logic         exp_carry;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[9];
    int   n_checks;
    int   n_errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!o_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!o_valid) begin
            n_checks++;
            n_errors++;
            $display("FAIL valid_timeout: o_valid=0 after %0d edges, expected 1", lat);
        end
    endtask

    // Drives start for one edge; lat counts edges from the start edge (inclusive) to valid.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                          output int lat);
        i_a     = a;
        i_b     = b;
        i_sub   = sub;
        i_start = 1'b1;
        check("ready_before_start", {31'd0, o_ready}, 32'd1);
        @(posedge clk);
        #1;
        i_start = 1'b0;
        wait_valid(lat);
    endtask

    task automatic do_ack();
        i_ack = 1'b1;
        @(posedge clk);
        #1;
        i_ack = 1'b0;
        check("ack_ready", {31'd0, o_ready}, 32'd1);
        check("ack_valid", {31'd0, o_valid}, 32'd0);
    endtask

    initial begin
        int lat;
        n_checks = 0;
        n_errors = 0;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[3] = '{8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0};
        vecs[4] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[6] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[7] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[8] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};

        i_reset = 1'b1;
        i_start = 1'b0;
        i_sub   = 1'b0;
        i_a     = '0;
        i_b     = '0;
        i_ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",  {31'd0, o_ready}, 32'd1);
        check("rst_valid",  {31'd0, o_valid}, 32'd0);
        check("rst_result", {24'd0, o_result}, 32'd0);
        check("rst_carry",  {31'd0, o_carry}, 32'd0);
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
        check("rst_ovf",    {31'd0, o_overflow}, 32'd0);
`endif
        i_reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
            check($sformatf("vec%0d_latency", i), lat, N + 1);
            check($sformatf("vec%0d_result", i), {24'd0, o_result}, {24'd0, vecs[i].exp_res});
            check($sformatf("vec%0d_carry", i), {31'd0, o_carry}, {31'd0, vecs[i].exp_carry});
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
            check($sformatf("vec%0d_ovf", i), {31'd0, o_overflow}, {31'd0, vecs[i].exp_ovf});
`endif
            do_ack();
            check($sformatf("vec%0d_result_kept", i), {24'd0, o_result}, {24'd0, vecs[i].exp_res});
        end

        // Result held while ack is withheld
        run_op(8'h07, 8'h05, 1'b1, lat);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("hold_valid",  {31'd0, o_valid}, 32'd1);
            check("hold_result", {24'd0, o_result}, 32'd2);
            check("hold_carry",  {31'd0, o_carry}, 32'd1);
        end
        do_ack();

        // Start pulse during RUN is ignored
        i_a = 8'h10; i_b = 8'h20; i_sub = 1'b0; i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("run_ready", {31'd0, o_ready}, 32'd0);
        i_a = 8'hAA; i_b = 8'h55; i_sub = 1'b1; i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        wait_valid(lat);
        check("ignored_start_result", {24'd0, o_result}, 32'h30);
        check("ignored_start_carry",  {31'd0, o_carry}, 32'd0);

        // Ack and start together in DONE: ack wins, no new operation
        i_ack = 1'b1; i_start = 1'b1; i_a = 8'hAA;
        @(posedge clk);
        #1;
        i_ack = 1'b0; i_start = 1'b0;
        check("ackstart_ready", {31'd0, o_ready}, 32'd1);
        check("ackstart_valid", {31'd0, o_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("ackstart_still_idle", {31'd0, o_ready}, 32'd1);
        check("ackstart_result", {24'd0, o_result}, 32'h30);

        // Reset at RUN cycle 4
        i_a = 8'h33; i_b = 8'h11; i_sub = 1'b0; i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        i_reset = 1'b1;
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        check("midrst_ready",  {31'd0, o_ready}, 32'd1);
        check("midrst_valid",  {31'd0, o_valid}, 32'd0);
        check("midrst_result", {24'd0, o_result}, 32'd0);
        check("midrst_carry",  {31'd0, o_carry}, 32'd0);
        run_op(8'h01, 8'h01, 1'b0, lat);
        check("post_rst_latency", lat, N + 1);
        check("post_rst_result", {24'd0, o_result}, 32'h02);
        check("post_rst_carry",  {31'd0, o_carry}, 32'd0);
        do_ack();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
